// File: rtl/sram_nr1w_pipe.sv
// Multi-read-port, single byte-masked write port word SRAM with optional post-reset zero fill.
// Latency: read data and rvalid appear RD_LAT cycles after the request; writes commit on the accepting edge.
// Backpressure: none on reads; writes and reads are refused (wr_ready=0) and flagged in drop_err while clearing.
module sram_nr1w_pipe #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int BYTE_W          = DATA_W / 8,
    parameter int NUM_RD          = 2,
    parameter int RD_LAT          = 2,
    parameter int CONFLICT_POLICY = 1,
    parameter int INIT_CLEAR      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [BYTE_W-1:0]          wr_mask,
    output logic                       wr_ready,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_rdata,
    output logic [NUM_RD-1:0]          rd_rvalid,
    output logic                       drop_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [ADDR_W-1:0]   clr_ptr_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_fire;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BYTE_W-1:0]   mem_wmask;

    logic [NUM_RD-1:0]   rd_fire;
    logic [DATA_W-1:0]   s1_dat   [NUM_RD];
    logic [RD_LAT-1:0]   pipe_vld [NUM_RD];
    logic [DATA_W-1:0]   pipe_dat [NUM_RD][RD_LAT];

    // Clear sequencer: one word per cycle, leaves CLEAR on the edge that writes the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        init_busy   = 1'b0;
        case (state)
            ST_CLEAR: begin
                init_busy   = 1'b1;
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == {ADDR_W{1'b1}}) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign wr_ready = !init_busy;
    assign wr_fire  = wr_en && wr_ready;

    // The clear sequencer and the user port share the single write port of the array.
    assign mem_we    = init_busy || wr_fire;
    assign mem_waddr = init_busy ? clr_ptr : wr_addr;
    assign mem_wdata = init_busy ? '0 : wr_data;
    assign mem_wmask = init_busy ? '1 : wr_mask;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTE_W; b++) begin
                if (mem_wmask[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Stage-1 read word; with write-first the same-edge write bytes are bypassed in.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_fire[p] = rd_en[p] && !init_busy;
            s1_dat[p]  = mem[rd_addr[p*ADDR_W +: ADDR_W]];
            if ((CONFLICT_POLICY == 1) && wr_fire &&
                (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
                for (int b = 0; b < BYTE_W; b++) begin
                    if (wr_mask[b]) begin
                        s1_dat[p][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Data registers load only behind a valid bit, so the last stage holds its value between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_RD; p++) begin
                pipe_vld[p] <= '0;
                for (int s = 0; s < RD_LAT; s++) begin
                    pipe_dat[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                pipe_vld[p][0] <= rd_fire[p];
                if (rd_fire[p]) begin
                    pipe_dat[p][0] <= s1_dat[p];
                end
                for (int s = 1; s < RD_LAT; s++) begin
                    pipe_vld[p][s] <= pipe_vld[p][s-1];
                    if (pipe_vld[p][s-1]) begin
                        pipe_dat[p][s] <= pipe_dat[p][s-1];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_out
        assign rd_rvalid[p]                = pipe_vld[p][RD_LAT-1];
        assign rd_rdata[p*DATA_W +: DATA_W] = pipe_dat[p][RD_LAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err <= 1'b0;
        end else if (init_busy && (wr_en || (|rd_en))) begin
            drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_nr1w_pipe.sv
// Drives a write-first RD_LAT=2 instance and a read-first RD_LAT=4 instance from shared stimulus,
// comparing both against a word-array model with per-cycle expected-pulse slots.
module tb_sram_nr1w_pipe;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_mask = '0;
    logic [1:0]  rd_en = '0;
    logic [7:0]  rd_addr = '0;

    logic [1:0]  init_busy_d;
    logic [1:0]  wr_ready_d;
    logic [1:0]  drop_err_d;
    logic [1:0]  rd_rvalid_d [2];
    logic [63:0] rd_rdata_d  [2];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          busy_left = 0;
    logic        exp_drop = 1'b0;
    logic [31:0] mem_m [DEPTH];
    bit          ev    [2][2][64];
    logic [31:0] ed    [2][2][64];
    logic [31:0] held  [2][2];

    always #5 clk = ~clk;

    sram_nr1w_pipe #(.ADDR_W(4), .DATA_W(32), .NUM_RD(2), .RD_LAT(2),
                     .CONFLICT_POLICY(1), .INIT_CLEAR(1)) dut_wf (
        .clk(clk), .rst(rst), .init_busy(init_busy_d[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_ready(wr_ready_d[0]), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_rdata(rd_rdata_d[0]), .rd_rvalid(rd_rvalid_d[0]), .drop_err(drop_err_d[0])
    );

    sram_nr1w_pipe #(.ADDR_W(4), .DATA_W(32), .NUM_RD(2), .RD_LAT(4),
                     .CONFLICT_POLICY(0), .INIT_CLEAR(1)) dut_rf (
        .clk(clk), .rst(rst), .init_busy(init_busy_d[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_ready(wr_ready_d[1]), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_rdata(rd_rdata_d[1]), .rd_rvalid(rd_rvalid_d[1]), .drop_err(drop_err_d[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic post(input int d, input int p, input logic [31:0] dat);
        int s;
        s = (cyc + lat(d) - 1) % 64;
        ev[d][p][s] = 1'b1;
        ed[d][p][s] = dat;
    endtask

    // Applies the effect of one clock edge to the model, using the inputs present at that edge.
    task automatic model_edge();
        logic [31:0] old;
        logic [3:0]  a;
        cyc++;
        if (busy_left > 0) begin
            if (wr_en || rd_en != 2'b00) exp_drop = 1'b1;
            busy_left--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rd_en[p]) begin
                    a   = rd_addr[p*4 +: 4];
                    old = mem_m[a];
                    post(0, p, (wr_en && wr_addr == a) ? merge(old, wr_data, wr_mask) : old);
                    post(1, p, old);
                end
            end
            if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_mask);
        end
    endtask

    task automatic check_all();
        int s;
        s = cyc % 64;
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("init_busy d%0d", d), init_busy_d[d], busy_left > 0);
            chk1($sformatf("wr_ready d%0d", d), wr_ready_d[d], !(busy_left > 0));
            chk1($sformatf("drop_err d%0d", d), drop_err_d[d], exp_drop);
            for (int p = 0; p < 2; p++) begin
                if (ev[d][p][s]) begin
                    chk1($sformatf("rvalid d%0d p%0d cyc%0d", d, p, cyc), rd_rvalid_d[d][p], 1'b1);
                    chk32($sformatf("rdata d%0d p%0d cyc%0d", d, p, cyc),
                          rd_rdata_d[d][p*32 +: 32], ed[d][p][s]);
                    held[d][p] = ed[d][p][s];
                    ev[d][p][s] = 1'b0;
                end else begin
                    chk1($sformatf("rvalid idle d%0d p%0d cyc%0d", d, p, cyc), rd_rvalid_d[d][p], 1'b0);
                    chk32($sformatf("rdata hold d%0d p%0d cyc%0d", d, p, cyc),
                          rd_rdata_d[d][p*32 +: 32], held[d][p]);
                end
            end
        end
    endtask

    task automatic cycle(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                         input logic [3:0] wm, input logic [1:0] re,
                         input logic [3:0] ra0, input logic [3:0] ra1);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_mask = wm;
        rd_en   = re;
        rd_addr = {ra1, ra0};
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 4'd0, 2'b00, 4'd0, 4'd0);
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 2'b00;
        rst   = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("rst drop_err d%0d", d), drop_err_d[d], 1'b0);
            chk1($sformatf("rst init_busy d%0d", d), init_busy_d[d], 1'b1);
            for (int p = 0; p < 2; p++) begin
                chk1($sformatf("rst rvalid d%0d p%0d", d, p), rd_rvalid_d[d][p], 1'b0);
                chk32($sformatf("rst rdata d%0d p%0d", d, p), rd_rdata_d[d][p*32 +: 32], 32'd0);
                held[d][p] = '0;
                for (int s = 0; s < 64; s++) ev[d][p][s] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        exp_drop = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        busy_left = DEPTH;
        check_all();
    endtask

    task automatic rand_cycles(input int n);
        logic       we;
        logic [3:0] wa, wm, ra0, ra1;
        logic [1:0] re;
        for (int i = 0; i < n; i++) begin
            we  = 1'($urandom_range(1));
            wa  = 4'($urandom_range(15));
            wm  = 4'($urandom_range(15));
            re  = 2'($urandom_range(3));
            ra0 = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
            ra1 = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
            cycle(we, wa, $urandom, wm, re, ra0, ra1);
        end
    endtask

    initial begin
        #2;
        do_reset();

        // Clear window: a request near the end of the clear must be dropped and flagged.
        idle(14);
        cycle(1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF, 2'b01, 4'd2, 4'd0);
        idle(1);
        chk1("clear done", init_busy_d[0], 1'b0);

        // Every address reads zero after the clear.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, 4'(i), 4'(15 - i));
        idle(4);

        // Simple write then read, with hold after the pulse.
        cycle(1'b1, 4'd5, 32'hDEAD_BEEF, 4'hF, 2'b00, 4'd0, 4'd0);
        cycle(1'b0, 4'd0, 32'd0, 4'd0, 2'b01, 4'd5, 4'd0);
        idle(1);
        chk1("t2 rvalid", rd_rvalid_d[0][0], 1'b1);
        chk32("t2 rdata", rd_rdata_d[0][31:0], 32'hDEAD_BEEF);
        idle(1);
        chk1("t2 rvalid low", rd_rvalid_d[0][0], 1'b0);
        chk32("t2 rdata hold", rd_rdata_d[0][31:0], 32'hDEAD_BEEF);
        idle(3);

        // Same-edge read/write conflict on both ports.
        cycle(1'b1, 4'd3, 32'h1122_3344, 4'hF, 2'b00, 4'd0, 4'd0);
        cycle(1'b1, 4'd3, 32'hAABB_CCDD, 4'h3, 2'b11, 4'd3, 4'd3);
        idle(1);
        chk32("t3 wf p0", rd_rdata_d[0][31:0], 32'h1122_CCDD);
        chk32("t3 wf p1", rd_rdata_d[0][63:32], 32'h1122_CCDD);
        idle(2);
        chk32("t3 rf p0", rd_rdata_d[1][31:0], 32'h1122_3344);
        chk32("t3 rf p1", rd_rdata_d[1][63:32], 32'h1122_3344);
        cycle(1'b0, 4'd0, 32'd0, 4'd0, 2'b01, 4'd3, 4'd0);
        idle(3);
        chk32("t3 later", rd_rdata_d[1][31:0], 32'h1122_CCDD);

        // Back-to-back streaming reads.
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), $urandom, 4'hF, 2'b00, 4'd0, 4'd0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, 4'(i), 4'(i));
        idle(5);

        rand_cycles(400);

        // Reset with reads in flight, then again partway through the clear.
        cycle(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, 4'd1, 4'd2);
        cycle(1'b0, 4'd0, 32'd0, 4'd0, 2'b11, 4'd3, 4'd4);
        do_reset();
        idle(7);
        do_reset();
        idle(DEPTH);
        rand_cycles(200);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_nr1w_pipe.md
Name: sram_nr1w_pipe

Overview:
Parametrised successor to the team's 1R/1W word SRAM. It has NUM_RD independent read ports, one byte-masked write port, a configurable fixed read latency RD_LAT and selectable READ_FIRST/WRITE_FIRST conflict policy. An optional post-reset clear sequencer zeroes the array, so large matrix buffers in the EPU start from a known state. It sits between the AXI-Lite/DMA write side and the multi-lane compute read side.

Parameters:
ADDR_W, 10, word address width; DEPTH = 2**ADDR_W
DATA_W, 32, word width; must be a multiple of 8
BYTE_W, DATA_W/8, write-mask width
NUM_RD, 2, number of read ports (1..8)
RD_LAT, 2, read latency in cycles (1..4)
CONFLICT_POLICY, 1, 0=READ_FIRST, 1=WRITE_FIRST
INIT_CLEAR, 1, 1=zero the array after reset; 0=array contents undefined after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
init_busy  out  1  high while the clear sequence runs
wr_en  in  1  write request
wr_addr  in  ADDR_W  write word address
wr_data  in  DATA_W  write data
wr_mask  in  BYTE_W  byte enables; bit i covers data[8i+7:8i]
wr_ready  out  1  write accepted this cycle; equals !init_busy
rd_en  in  NUM_RD  per-port read request
rd_addr  in  NUM_RD*ADDR_W  port p address at [p*ADDR_W +: ADDR_W]
rd_rdata  out  NUM_RD*DATA_W  port p data at [p*DATA_W +: DATA_W]
rd_rvalid  out  NUM_RD  per-port data valid
drop_err  out  1  sticky: a request arrived while init_busy

Behaviour:
- Reset is asynchronous. On assertion:
  - rd_rvalid=0, rd_rdata=0, drop_err=0 immediately.
  - All pipeline valid bits are flushed.
  - Clear pointer is set to 0.
  - FSM goes to CLEAR if INIT_CLEAR=1, else IDLE.
  - Reset mid-read drops in-flight reads; no rvalid is produced for them.
  - Reset mid-clear restarts the clear from address 0.
- FSM states:
  - CLEAR: each cycle write 0 to mem[clr_ptr], then clr_ptr++. When clr_ptr==DEPTH-1 is written, go to IDLE on the next edge.
  - IDLE: normal operation; no exit except reset.
  - Clear takes exactly DEPTH cycles after reset deassertion.
- Outputs per state:
  - init_busy=1 only in CLEAR. wr_ready = !init_busy.
  - In CLEAR, wr_en and rd_en are ignored: no write, no rvalid. Any asserted request sets drop_err=1.
- Write: the commit happens at the clock edge when wr_en && wr_ready. Only the bytes with mask bit set change. wr_mask=0 is a legal no-op.
- Read of port p sampled at edge t (rd_en[p] && !init_busy):
  - rd_rvalid[p]=1 and rd_rdata are presented after edge t+RD_LAT-1, i.e. visible for one cycle RD_LAT cycles after the request cycle.
  - Data equals the array contents produced by all writes committed before edge t.
  - If CONFLICT_POLICY=1 and a write to the same address commits at edge t, that write's masked bytes are merged into the returned data.
  - If CONFLICT_POLICY=0, the write at edge t is not visible.
  - Writes after edge t never affect the returned data.
- Pipeline:
  - Stage 1 registers the array read plus the merge.
  - Stages 2..RD_LAT are pure delay registers, each carrying a valid bit.
  - Throughput is one read per port per cycle; back-to-back reads are permitted; there is no backpressure.
- rd_rdata[p] updates only when the final stage is valid; otherwise it holds its last value. rd_rvalid is a single-cycle pulse per request.
- Ports are fully independent. Identical addresses on several read ports all return identical data. No arbitration is needed.
- Address wrap: addresses are ADDR_W bits, so there is no out-of-range access.
- drop_err clears only on rst.

Test Plan:
1. Reset, INIT_CLEAR=1, ADDR_W=4 -> init_busy=1 for exactly 16 cycles, wr_ready=0 during that time; afterwards every address reads 0x00000000.
2. Write 0xDEADBEEF to addr 5, mask 0xF; next cycle rd_en port0 addr 5, RD_LAT=2 -> rd_rvalid[0] pulses 2 cycles after the request with 0xDEADBEEF. rd_rdata then holds that value while rvalid=0.
3. mem[3]=0x11223344; in the same cycle write 0xAABBCCDD mask 0x3 and read addr 3 on both ports -> WRITE_FIRST returns 0x1122CCDD on both ports; READ_FIRST returns 0x11223344; a later read returns 0x1122CCDD.
4. Port0 and port1 issue reads to addrs 0..7 on consecutive cycles, RD_LAT=4 -> 8 consecutive rvalid pulses per port, in order, with data matching the model.
5. wr_en=1 and rd_en=2'b01 during CLEAR -> no write committed, no rvalid, drop_err=1 and stays set until rst.
6. Assert rst while 2 reads are in flight and clear is at ptr=7 -> rd_rvalid=0 immediately and no pulses follow; the clear restarts and init_busy lasts a full DEPTH cycles.
